// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder.
//   - state_t       : controller states (LOAD -> ADD -> DONE)
//   - DEFAULT_WIDTH : default operand/sum width in bits
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Purely combinational 1-bit full adder; the single arithmetic cell that the
//   serial adder reuses on every ADD cycle.
//   Ports:
//     a, b  : input  operand bits
//     cin   : input  carry in
//     s     : output sum bit
//     cout  : output carry out (majority of a, b, cin)
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_adder4.sv
// -----------------------------------------------------------------------------
// serial_adder4
//   Bit-serial ripple adder. After reset is released, the first clock edge
//   captures data_a/data_b, then WIDTH edges add one bit per clock (LSB first)
//   through one full adder and a carry flop. The sum is shifted in from the
//   MSB end and held, together with the final carry, until the next reset.
//   Ports:
//     clk       : input  rising-edge clock
//     reset     : input  asynchronous, active-low; 0 clears all state
//     data_a    : input  [WIDTH] operand A, sampled in LOAD only
//     data_b    : input  [WIDTH] operand B, sampled in LOAD only
//     out       : output [WIDTH] sum shift register (partial in ADD, final in DONE)
//     done      : output high while in DONE
//     carry_out : output carry flop; final carry when done=1
// -----------------------------------------------------------------------------
module serial_adder4
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             carry_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    // Counter value seen on the final ADD edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;

    logic fa_s;
    logic fa_cout;

    // The LSBs of the operand shift registers are the current bit position.
    full_adder u_full_adder (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        // NOTE: every signal gets a hold default first so no path through the
        // case leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        done_d  = done_q;

        unique case (state_q)
            S_LOAD: begin
                a_d     = data_a;
                b_d     = data_b;
                carry_d = 1'b0;
                out_d   = '0;
                cnt_d   = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                // New sum bit enters at the MSB so that after WIDTH shifts
                // bit 0 of the sum has reached out[0].
                out_d   = {fa_s, out_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                // Everything holds; only reset leaves this state.
            end
            default: state_d = S_LOAD;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above, regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOAD;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign out       = out_q;
    assign done      = done_q;
    assign carry_out = carry_q;

endmodule : serial_adder4

// File: tb/tb_serial_adder4.sv
// -----------------------------------------------------------------------------
// tb_serial_adder4
//   Self-checking bench for serial_adder4 (WIDTH=4). Expected values come from
//   plain integer arithmetic: after k ADD edges the low k sum bits sit at the
//   top of out, and the carry is the carry out of the low k bits.
// -----------------------------------------------------------------------------
module tb_serial_adder4;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic [W-1:0] out;
    logic         done;
    logic         carry_out;

    int checks;
    int errors;

    serial_adder4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_a    (data_a),
        .data_b    (data_b),
        .out       (out),
        .done      (done),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: partial sum register after k ADD edges.
    function automatic logic [W-1:0] model_out(input int a, input int b, input int k);
        int m;
        int s;
        if (k == 0) return '0;
        m = (1 << k) - 1;
        s = (a + b) & m;
        return W'(s << (W - k));
    endfunction

    // Reference: carry after k ADD edges = carry out of the low k bits.
    function automatic logic model_carry(input int a, input int b, input int k);
        int m;
        m = (1 << k) - 1;
        return 1'(((a & m) + (b & m)) >> k);
    endfunction

    task automatic compare_state(input string tag, input int a, input int b, input int k);
        logic [W-1:0] e_out;
        logic         e_c;
        logic         e_d;
        e_out = model_out(a, b, k);
        e_c   = (k == 0) ? 1'b0 : model_carry(a, b, k);
        e_d   = (k == W);
        checks++;
        if (out !== e_out || carry_out !== e_c || done !== e_d) begin
            errors++;
            $display("FAIL %s k=%0d: out=%b carry=%b done=%b, expected out=%b carry=%b done=%b",
                     tag, k, out, carry_out, done, e_out, e_c, e_d);
        end
    endtask

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Release reset with operands a/b, then run the LOAD edge and n_add ADD
    // edges, comparing after each. With scramble set, the operand inputs are
    // randomised before every ADD edge.
    task automatic run_add(input string tag, input int a, input int b,
                           input int n_add, input bit scramble);
        @(negedge clk);
        data_a = W'(a);
        data_b = W'(b);
        reset  = 1'b1;
        #1;
        compare_state({tag, "/pre_edge"}, a, b, 0);
        @(posedge clk);
        #1;
        compare_state({tag, "/load"}, a, b, 0);
        for (int k = 1; k <= n_add; k++) begin
            @(negedge clk);
            if (scramble) begin
                data_a = W'($urandom);
                data_b = W'($urandom);
            end
            @(posedge clk);
            #1;
            compare_state(tag, a, b, k);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        data_a = '0;
        data_b = '0;
        #30;
        checks++;
        if (out !== '0 || done !== 1'b0 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL reset: out=%b done=%b carry=%b, expected 0 0 0", out, done, carry_out);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] seq [5];
        hold_reset();
        seq = '{4'b0000, 4'b0000, 4'b1000, 4'b1100, 4'b1110};
        @(negedge clk);
        data_a = 4'b1101;
        data_b = 4'b0001;
        reset  = 1'b1;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out !== seq[e]) begin
                errors++;
                $display("FAIL basic edge %0d: out=%b, expected %b", e + 1, out, seq[e]);
            end
        end
        checks++;
        if (done !== 1'b1 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL basic final: done=%b carry=%b, expected 1 0", done, carry_out);
        end
    endtask

    task automatic test_overflow();
        hold_reset();
        run_add("overflow", 4'b1111, 4'b0001, W, 1'b0);
    endtask

    task automatic test_zero_max();
        hold_reset();
        run_add("zero", 0, 0, W, 1'b0);
        hold_reset();
        run_add("max", 4'b1111, 4'b1111, W, 1'b0);
    endtask

    task automatic test_operand_change();
        hold_reset();
        @(negedge clk);
        data_a = 4'b0011;
        data_b = 4'b0100;
        reset  = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            data_a = 4'b1111;
            @(posedge clk);
            #1;
            compare_state("operand_change", 4'b0011, 4'b0100, k);
        end
        run_add_scramble_check();
    endtask

    task automatic run_add_scramble_check();
        hold_reset();
        run_add("scramble", 4'b1010, 4'b0111, W, 1'b1);
    endtask

    task automatic test_reset_mid_add();
        hold_reset();
        run_add("mid_pre", 4'b1011, 4'b0110, 2, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (out !== '0 || done !== 1'b0 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_add_async_reset: out=%b done=%b carry=%b, expected 0 0 0",
                     out, done, carry_out);
        end
        @(negedge clk);
        run_add("mid_restart", 4'b0101, 4'b0110, W, 1'b0);
    endtask

    task automatic test_hold_done();
        int a;
        int b;
        a = 4'b1001;
        b = 4'b1110;
        hold_reset();
        run_add("hold_run", a, b, W, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            data_a = W'($urandom);
            data_b = W'($urandom);
            @(posedge clk);
            #1;
            compare_state("hold_done", a, b, W);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            hold_reset();
            run_add("random", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    W, n[0]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_zero_max();
        test_operand_change();
        test_reset_mid_add();
        test_hold_done();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_serial_adder4
